// File: rtl/irq_trig_chan.sv
// rtl/irq_trig_chan.sv - one interrupt channel: synchroniser, glitch filter, state and trig flops
module irq_trig_chan #(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER      = 3,
   parameter logic RISE        = 1'b1,
   parameter logic FALL        = 1'b0,
   parameter logic LEVEL       = 1'b0,
   parameter logic INIT        = 1'b0
) (
   input  logic bus_clk,
   input  logic bus_reset_l,
   input  logic irq_in,
   output logic trig,
   output logic state
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   state_q;
   logic                   state_d;
   logic                   trig_q;
   logic                   trig_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};

   generate
      if (FILTER == 0) begin : g_bypass
         assign state_d = sync_d[SYNC_STAGES-1];
      end else begin : g_filter
         localparam int CW = $clog2(FILTER + 1);
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic          s;

         assign s = sync_q[SYNC_STAGES-1];

         // The count only survives while the synchronised input disagrees with state.
         always_comb begin
            cnt_d   = '0;
            state_d = state_q;
            if (s != state_q) begin
               if (cnt_q == CW'(FILTER - 1)) begin
                  state_d = s;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge bus_clk or negedge bus_reset_l) begin
            if (!bus_reset_l) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_comb begin
      trig_d = (RISE & state_d & ~state_q) | (FALL & ~state_d & state_q);
      if (LEVEL) begin
         trig_d = state_d;
      end
   end

   always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) begin
         sync_q  <= {SYNC_STAGES{INIT}};
         state_q <= INIT;
         trig_q  <= INIT & LEVEL;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         trig_q  <= trig_d;
      end
   end

   assign trig  = trig_q;
   assign state = state_q;

endmodule

// File: rtl/irq_trig_cond.sv
// rtl/irq_trig_cond.sv - per-channel interrupt input conditioner feeding the interrupt register
module irq_trig_cond #(
   parameter int                   DATAWIDTH   = 32,
   parameter int                   SYNC_STAGES = 2,
   parameter int                   FILTER      = 3,
   parameter logic [DATAWIDTH-1:0] RISE        = '1,
   parameter logic [DATAWIDTH-1:0] FALL        = '0,
   parameter logic [DATAWIDTH-1:0] LEVEL       = '0,
   parameter logic [DATAWIDTH-1:0] INIT        = '0
) (
   input  logic                 bus_clk,
   input  logic                 bus_reset_l,
   input  logic [DATAWIDTH-1:0] irq_in,
   output logic [DATAWIDTH-1:0] trig,
   output logic [DATAWIDTH-1:0] state
);

   generate
      for (genvar i = 0; i < DATAWIDTH; i++) begin : g_chan
         irq_trig_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER      (FILTER),
            .RISE        (RISE[i]),
            .FALL        (FALL[i]),
            .LEVEL       (LEVEL[i]),
            .INIT        (INIT[i])
         ) u_chan (
            .bus_clk     (bus_clk),
            .bus_reset_l (bus_reset_l),
            .irq_in      (irq_in[i]),
            .trig        (trig[i]),
            .state       (state[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_irq_trig_cond.sv
// tb/tb_irq_trig_cond.sv - randomized and directed check of irq_trig_cond against a window-based model
module tb_irq_trig_cond;

   localparam int         DW = 4;
   localparam int         SS = 2;
   localparam int         FL = 3;
   localparam logic [3:0] RM = 4'b0011;
   localparam logic [3:0] FM = 4'b0010;
   localparam logic [3:0] LM = 4'b0100;
   localparam logic [3:0] IM = 4'b0000;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic [DW-1:0] irq = 4'hF;
   logic [DW-1:0] trig;
   logic [DW-1:0] state;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] mq[$];
   logic [3:0] m_state;
   logic [3:0] m_trig;

   irq_trig_cond #(
      .DATAWIDTH   (DW),
      .SYNC_STAGES (SS),
      .FILTER      (FL),
      .RISE        (RM),
      .FALL        (FM),
      .LEVEL       (LM),
      .INIT        (IM)
   ) dut (
      .bus_clk     (clk),
      .bus_reset_l (rst_l),
      .irq_in      (irq),
      .trig        (trig),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Samples taken before the first edge after reset are the synchroniser's INIT contents.
   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < SS + FL; i++) mq.push_back(IM);
      m_state = IM;
      m_trig  = IM & LM;
   endtask

   // A channel flips once the last FL synchronised values all disagree with its state.
   task automatic model_edge(input logic [3:0] smp);
      logic [3:0] nst;
      bit ok;
      mq.push_back(smp);
      nst = m_state;
      for (int ch = 0; ch < DW; ch++) begin
         ok = 1'b1;
         for (int j = 0; j < FL; j++) begin
            if (mq[mq.size() - 1 - SS - j][ch] == m_state[ch]) ok = 1'b0;
         end
         if (ok) nst[ch] = ~m_state[ch];
      end
      m_trig  = (LM & nst) | (~LM & ((RM & nst & ~m_state) | (FM & ~nst & m_state)));
      m_state = nst;
      while (mq.size() > SS + FL) void'(mq.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(irq);
      #1;
      check("state", state, m_state);
      check("trig", trig, m_trig);
   endtask

   task automatic hold(input logic [3:0] v, input int n);
      irq = v;
      repeat (n) tick();
   endtask

   task automatic pulse_reset();
      rst_l = 1'b0;
      #2;
      check("rst_trig", trig, IM & LM);
      check("rst_state", state, IM);
      model_reset();
      #1;
      rst_l = 1'b1;
   endtask

   int pulses;
   int first_at;
   int second_at;
   int high_cnt;

   initial begin
      model_reset();
      #12;
      check("por_trig", trig, IM & LM);
      check("por_state", state, IM);
      rst_l = 1'b1;
      hold(4'hF, 3);

      // 1: reset with all inputs high, then full report after release
      @(posedge clk);
      #1;
      pulse_reset();
      hold(4'hF, 5);
      check("rel_state_k4", state, 4'hF);
      check("rel_trig_k4", trig, 4'b0111);
      hold(4'hF, 1);
      check("rel_trig_k5", trig, 4'b0100);
      hold(4'h0, 8);

      // 2: rise then fall on channel 0
      hold(4'h1, 4);
      check("rise_pre", trig, 4'b0000);
      hold(4'h1, 1);
      check("rise_trig", trig, 4'b0001);
      hold(4'h1, 1);
      check("rise_one", trig, 4'b0000);
      hold(4'h1, 4);
      hold(4'h0, 8);
      check("fall_state", state, 4'b0000);

      // 3: glitches of 2 and 3 cycles
      hold(4'h1, 2);
      pulses = 0;
      irq = 4'h0;
      repeat (8) begin
         tick();
         if (trig[0] || state[0]) pulses++;
      end
      check("glitch2", 4'(pulses), 4'd0);
      hold(4'h1, 3);
      pulses = 0;
      irq = 4'h0;
      repeat (10) begin
         tick();
         if (trig[0]) pulses++;
      end
      check("glitch3", 4'(pulses), 4'd1);

      // 4: both edges on channel 1, pulses 10 apart
      pulses = 0;
      first_at = -1;
      second_at = -1;
      for (int t = 0; t < 24; t++) begin
         irq = (t < 10) ? 4'h2 : 4'h0;
         tick();
         if (trig[1]) begin
            pulses++;
            if (first_at < 0) first_at = t;
            else second_at = t;
         end
      end
      check("both_cnt", 4'(pulses), 4'd2);
      check("both_gap", 4'(second_at - first_at), 4'd10);

      // 5: level channel 2 while channel 3 toggles
      high_cnt = 0;
      pulses = 0;
      for (int t = 0; t < 34; t++) begin
         irq = {((t / 5) % 2 == 1), (t < 20), 2'b00};
         tick();
         if (trig[2]) high_cnt++;
         if (trig[3]) pulses++;
      end
      check("level_len", 5'(high_cnt) == 5'd20 ? 4'd1 : 4'd0, 4'd1);
      check("mask_none", 4'(pulses), 4'd0);
      hold(4'h0, 8);

      // 6: simultaneous rise, then repeated toggling of channel 0
      hold(4'h3, 5);
      check("simul", trig, 4'b0011);
      hold(4'h3, 1);
      hold(4'h2, 8);
      pulses = 0;
      for (int t = 0; t < 60; t++) begin
         irq = {3'b001, ((t / 6) % 2 == 1)};
         tick();
         if (trig[0]) pulses++;
      end
      hold(4'h2, 8);
      check("toggle_cnt", 4'(pulses), 4'd5);

      // mid-operation reset with a filter count in flight
      hold(4'h5, 2);
      @(posedge clk);
      #1;
      pulse_reset();
      hold(4'h5, 10);
      hold(4'h0, 10);

      // random phase: slow toggling per bit plus occasional resets
      for (int t = 0; t < 800; t++) begin
         logic [3:0] nx;
         nx = irq;
         for (int b = 0; b < DW; b++) begin
            if ($urandom_range(0, 5) == 0) nx[b] = ~nx[b];
         end
         if ($urandom_range(0, 150) == 0) begin
            @(posedge clk);
            #1;
            pulse_reset();
         end
         hold(nx, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
